// File: rtl/foreground_prefetch_scheduler_pkg.sv
// Shared constants and helpers for the foreground prefetch scheduler.
// Provides SCREEN_HEIGHT, the line coordinate width and the look-ahead sum.
package foreground_prefetch_scheduler_pkg;

  localparam int Y_W           = 8;
  localparam int SCREEN_HEIGHT = 240;

  // One extra bit so Y+P never wraps before the height compare.
  function automatic logic [Y_W:0] lookahead(
    input logic [Y_W-1:0] y,
    input logic [Y_W:0]   p
  );
    return {1'b0, y} + p;
  endfunction

endpackage

// File: rtl/foreground_prefetch_scheduler.sv
// Issues one prefetch start per upcoming scanline into the foreground engine.
// Ports: gpu_clk/rst, timing pulses in, fg_idle_i, start/y/busy/status out.
module foreground_prefetch_scheduler #(
  parameter int PREFETCH_SCANLINES = 1,
  parameter int SCREEN_HEIGHT =
    foreground_prefetch_scheduler_pkg::SCREEN_HEIGHT
) (
  input  logic       gpu_clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       frame_start_i,
  input  logic       line_start_i,
  input  logic [7:0] display_y_i,
  input  logic       fg_idle_i,
  input  logic       clear_status_i,
  output logic       prefetch_start_o,
  output logic [7:0] prefetch_y_o,
  output logic       busy_o,
  output logic       overrun_o,
  output logic [7:0] drop_count_o
);
  import foreground_prefetch_scheduler_pkg::*;

  typedef enum logic [1:0] {
    OFF,
    PRIME,
    RUN
  } state_t;

  localparam logic [8:0] P9 = 9'(PREFETCH_SCANLINES);
  localparam logic [8:0] H9 = 9'(SCREEN_HEIGHT);

  state_t     state_q, state_d;
  logic [7:0] next_y_q, next_y_d;
  logic [8:0] prime_left_q, prime_left_d;
  logic       pending_q, pending_d;
  logic [7:0] pend_y_q, pend_y_d;
  logic       cooldown_q, cooldown_d;
  logic       start_d;
  logic [7:0] y_d;
  logic       busy_d;
  logic       overrun_d;
  logic [7:0] drop_d;

  logic [8:0] ahead;
  logic       req_ok;
  logic       line_ev;
  logic       issue_prime;
  logic       issue_run;
  logic       supersede;
  logic       late;

  always_comb begin
    state_d      = state_q;
    next_y_d     = next_y_q;
    prime_left_d = prime_left_q;
    pending_d    = pending_q;
    pend_y_d     = pend_y_q;
    cooldown_d   = 1'b0;
    start_d      = 1'b0;
    y_d          = prefetch_y_o;
    overrun_d    = overrun_o;
    drop_d       = drop_count_o;

    ahead   = lookahead(display_y_i, P9);
    req_ok  = ahead < H9;
    // frame_start_i wins over a coincident line.
    line_ev = line_start_i & ~frame_start_i &
              enable_i & (state_q != OFF);

    issue_prime = (state_q == PRIME) &
                  (prime_left_q != 9'd0) &
                  fg_idle_i & ~cooldown_q;
    issue_run   = (state_q == RUN) & pending_q &
                  fg_idle_i & ~cooldown_q;

    // A request issued on this edge is not dropped.
    supersede = line_ev & req_ok & pending_q & ~issue_run;
    late      = line_ev & (state_q == PRIME);

    if (!enable_i) begin
      state_d      = OFF;
      pending_d    = 1'b0;
      prime_left_d = 9'd0;
    end else if (frame_start_i) begin
      state_d      = PRIME;
      next_y_d     = 8'd0;
      prime_left_d = P9;
      pending_d    = 1'b0;
    end else begin
      if (issue_prime) begin
        start_d      = 1'b1;
        y_d          = next_y_q;
        next_y_d     = next_y_q + 8'd1;
        prime_left_d = prime_left_q - 9'd1;
        cooldown_d   = 1'b1;
      end
      if (issue_run) begin
        start_d    = 1'b1;
        y_d        = pend_y_q;
        pending_d  = 1'b0;
        cooldown_d = 1'b1;
      end
      if (state_q == PRIME &&
          (prime_left_q == 9'd0 ||
           (issue_prime && prime_left_q == 9'd1)))
        state_d = RUN;
      if (line_ev && req_ok) begin
        pending_d = 1'b1;
        pend_y_d  = ahead[7:0];
      end
    end

    if (clear_status_i) begin
      overrun_d = 1'b0;
      drop_d    = 8'd0;
    end
    if (supersede | late)
      overrun_d = 1'b1;
    if (supersede && drop_d != 8'hff)
      drop_d = drop_d + 8'd1;

    busy_d = (state_d == PRIME) | pending_d;
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      state_q          <= OFF;
      next_y_q         <= 8'd0;
      prime_left_q     <= 9'd0;
      pending_q        <= 1'b0;
      pend_y_q         <= 8'd0;
      cooldown_q       <= 1'b0;
      prefetch_start_o <= 1'b0;
      prefetch_y_o     <= 8'd0;
      busy_o           <= 1'b0;
      overrun_o        <= 1'b0;
      drop_count_o     <= 8'd0;
    end else begin
      state_q          <= state_d;
      next_y_q         <= next_y_d;
      prime_left_q     <= prime_left_d;
      pending_q        <= pending_d;
      pend_y_q         <= pend_y_d;
      cooldown_q       <= cooldown_d;
      prefetch_start_o <= start_d;
      prefetch_y_o     <= y_d;
      busy_o           <= busy_d;
      overrun_o        <= overrun_d;
      drop_count_o     <= drop_d;
    end
  end

endmodule

// File: tb/tb_foreground_prefetch_scheduler.sv
// Scoreboard bench for foreground_prefetch_scheduler (P=1 and P=2 instances).
// Expected start lines are queued at stimulus time and popped on each start.
module tb_foreground_prefetch_scheduler;

  logic       gpu_clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, fs = 1'b0, ls = 1'b0;
  logic [7:0] dy = 8'd0;
  logic       idle = 1'b1, clr = 1'b0;
  logic       start;
  logic [7:0] py;
  logic       busy, ovr;
  logic [7:0] drop;

  logic       en2 = 1'b0, fs2 = 1'b0;
  logic       idle2 = 1'b1;
  logic       start2;
  logic [7:0] py2;
  logic       busy2, ovr2;
  logic [7:0] drop2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts1 = 0;
  int starts2 = 0;
  int last2 = -100;
  int idle_cnt = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  foreground_prefetch_scheduler #(.PREFETCH_SCANLINES(1)) dut (
    .gpu_clk(gpu_clk), .rst(rst), .enable_i(en),
    .frame_start_i(fs), .line_start_i(ls), .display_y_i(dy),
    .fg_idle_i(idle), .clear_status_i(clr),
    .prefetch_start_o(start), .prefetch_y_o(py),
    .busy_o(busy), .overrun_o(ovr), .drop_count_o(drop)
  );

  foreground_prefetch_scheduler #(.PREFETCH_SCANLINES(2)) dut2 (
    .gpu_clk(gpu_clk), .rst(rst), .enable_i(en2),
    .frame_start_i(fs2), .line_start_i(1'b0), .display_y_i(8'd0),
    .fg_idle_i(idle2), .clear_status_i(1'b0),
    .prefetch_start_o(start2), .prefetch_y_o(py2),
    .busy_o(busy2), .overrun_o(ovr2), .drop_count_o(drop2)
  );

  always #5 gpu_clk = ~gpu_clk;
  always @(posedge gpu_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  always @(negedge gpu_clk) begin
    if (start) begin
      starts1++;
      if (q1.size() == 0) chk("unexp_start1", {24'd0, py}, 32'hffff);
      else chk("start_y1", {24'd0, py}, {24'd0, q1.pop_front()});
    end
  end

  // Engine model for dut2: busy for 5 cycles after each start.
  always @(negedge gpu_clk) begin
    if (idle_cnt > 0) begin
      idle_cnt--;
      if (idle_cnt == 0) idle2 = 1'b1;
    end
    if (start2) begin
      starts2++;
      chk("gap2", (cyc - last2 >= 2) ? 32'd1 : 32'd0, 32'd1);
      last2 = cyc;
      if (q2.size() == 0) chk("unexp_start2", {24'd0, py2}, 32'hffff);
      else chk("start_y2", {24'd0, py2}, {24'd0, q2.pop_front()});
      idle2 = 1'b0;
      idle_cnt = 5;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge gpu_clk);
    #1;
  endtask

  task automatic pulse_line(input logic [7:0] y);
    ls = 1'b1;
    dy = y;
    cyc_wait(1);
    ls = 1'b0;
  endtask

  task automatic pulse_frame();
    fs = 1'b1;
    cyc_wait(1);
    fs = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    @(negedge gpu_clk);
    chk({tag, "_start"}, {31'd0, start}, 32'd0);
    chk({tag, "_y"}, {24'd0, py}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, ovr}, 32'd0);
    chk({tag, "_drop"}, {24'd0, drop}, 32'd0);
  endtask

  int snap;

  initial begin
    cyc_wait(3);
    chk_outs_zero("reset");
    cyc_wait(1);
    rst = 1'b0;
    en = 1'b1;
    idle = 1'b1;

    // Prime one line with P=1.
    q1.push_back(8'd0);
    pulse_frame();
    @(negedge gpu_clk);
    chk("prime_busy", {31'd0, busy}, 32'd1);
    cyc_wait(5);
    chk("prime_drained", q1.size(), 0);
    chk("prime_count", starts1, 1);
    chk("prime_busy_drop", {31'd0, busy}, 32'd0);

    // Line 10 -> start y=11 one cycle after the latching edge.
    q1.push_back(8'd11);
    pulse_line(8'd10);
    @(posedge gpu_clk);
    @(negedge gpu_clk);
    chk("lat_start", {31'd0, start}, 32'd1);
    chk("lat_y", {24'd0, py}, 32'd11);
    @(negedge gpu_clk);
    chk("pulse_width", {31'd0, start}, 32'd0);
    chk("y_hold", {24'd0, py}, 32'd11);

    // Last visible line produces no request.
    cyc_wait(2);
    snap = starts1;
    pulse_line(8'd239);
    cyc_wait(6);
    chk("no_start_239", starts1, snap);

    // Supersede while the engine is busy.
    idle = 1'b0;
    q1.push_back(8'd22);
    pulse_line(8'd20);
    pulse_line(8'd21);
    cyc_wait(3);
    idle = 1'b1;
    cyc_wait(5);
    chk("sup_drained", q1.size(), 0);
    chk("sup_ovr", {31'd0, ovr}, 32'd1);
    chk("sup_drop", {24'd0, drop}, 32'd1);
    clr = 1'b1;
    cyc_wait(1);
    clr = 1'b0;
    @(negedge gpu_clk);
    chk("clr_ovr", {31'd0, ovr}, 32'd0);
    chk("clr_drop", {24'd0, drop}, 32'd0);

    // Frame and line together: only the prime runs.
    cyc_wait(1);
    q1.push_back(8'd0);
    fs = 1'b1;
    ls = 1'b1;
    dy = 8'd5;
    cyc_wait(1);
    fs = 1'b0;
    ls = 1'b0;
    cyc_wait(8);
    chk("coinc_drained", q1.size(), 0);
    chk("coinc_ovr", {31'd0, ovr}, 32'd0);
    chk("coinc_busy", {31'd0, busy}, 32'd0);

    // 300 back-to-back lines with a stalled engine.
    idle = 1'b0;
    ls = 1'b1;
    for (int i = 0; i < 300; i++) begin
      dy = 8'(i % 200);
      cyc_wait(1);
    end
    ls = 1'b0;
    q1.push_back(8'd100);
    @(negedge gpu_clk);
    chk("stress_drop", {24'd0, drop}, 32'd255);
    chk("stress_ovr", {31'd0, ovr}, 32'd1);
    idle = 1'b1;
    cyc_wait(5);
    chk("stress_drained", q1.size(), 0);

    // Reset with a pending request.
    idle = 1'b0;
    pulse_line(8'd30);
    @(negedge gpu_clk);
    chk("rst_pend_busy", {31'd0, busy}, 32'd1);
    snap = starts1;
    rst = 1'b1;
    cyc_wait(1);
    chk_outs_zero("rst_mid");
    rst = 1'b0;
    idle = 1'b1;
    cyc_wait(10);
    chk("rst_no_start", starts1, snap);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Disable with a pending request.
    q1.push_back(8'd0);
    pulse_frame();
    cyc_wait(5);
    idle = 1'b0;
    pulse_line(8'd40);
    @(negedge gpu_clk);
    chk("dis_pend_busy", {31'd0, busy}, 32'd1);
    snap = starts1;
    en = 1'b0;
    cyc_wait(1);
    idle = 1'b1;
    cyc_wait(10);
    chk("dis_no_start", starts1, snap);
    chk("dis_busy", {31'd0, busy}, 32'd0);

    // P=2 prime with a toggling engine.
    en2 = 1'b1;
    q2.push_back(8'd0);
    q2.push_back(8'd1);
    fs2 = 1'b1;
    cyc_wait(1);
    fs2 = 1'b0;
    cyc_wait(30);
    chk("p2_drained", q2.size(), 0);
    chk("p2_count", starts2, 2);
    chk("p2_busy", {31'd0, busy2}, 32'd0);
    chk("p2_ovr", {31'd0, ovr2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
